// File: rtl/gcp_pkg.sv
// Shared definitions for the global command processor: register map,
// register field positions and AXI response codes.
package gcp_pkg;

   // Register map (byte addresses within the 4 KiB AXI4-Lite window)
   localparam logic [11:0] ADDR_CTRL       = 12'h000;
   localparam logic [11:0] ADDR_STATUS     = 12'h004;
   localparam logic [11:0] ADDR_IRQ_EN     = 12'h008;
   localparam logic [11:0] ADDR_IRQ_STATUS = 12'h00C;
   localparam logic [11:0] ADDR_PERF       = 12'h010;
   localparam logic [11:0] ADDR_TPC_BASE   = 12'h100;
   localparam int unsigned TPC_STRIDE      = 16;
   localparam int unsigned MAX_TPCS        = 8;

   // Offsets inside one per-TPC register block
   localparam logic [3:0] TPC_OFS_PC   = 4'h0;
   localparam logic [3:0] TPC_OFS_STAT = 4'h4;

   // Field positions
   localparam int unsigned CTRL_START_BIT    = 0;
   localparam int unsigned CTRL_MASK_LSB     = 8;
   localparam int unsigned STAT_BUSY_LSB     = 0;
   localparam int unsigned STAT_DONE_LSB     = 8;
   localparam int unsigned STAT_ERR_LSB      = 16;
   localparam int unsigned STAT_ALL_DONE_BIT = 31;
   localparam int unsigned IRQ_DONE_BIT      = 0;
   localparam int unsigned IRQ_ERR_BIT       = 1;
   localparam int unsigned PC_W              = 20;

   typedef enum logic [1:0] {
      RESP_OKAY   = 2'b00,
      RESP_EXOKAY = 2'b01,
      RESP_SLVERR = 2'b10,
      RESP_DECERR = 2'b11
   } axi_resp_e;

   // True when the address falls in the per-TPC register window
   // (ADDR_TPC_BASE .. ADDR_TPC_BASE + MAX_TPCS*TPC_STRIDE - 1)
   function automatic logic tpc_window(input logic [11:0] addr);
      return (addr[11:7] == ADDR_TPC_BASE[11:7]);
   endfunction

   // TPC index of an address inside the per-TPC window
   function automatic logic [2:0] tpc_index(input logic [11:0] addr);
      return addr[6:4];
   endfunction

endpackage

// File: rtl/gcp_barrier.sv
// Hardware barrier across the enabled TPCs: releases all of them with a
// one-cycle grant once every enabled TPC is requesting.
module gcp_barrier
   import gcp_pkg::*;
#(
   parameter int unsigned NUM_TPCS = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [NUM_TPCS-1:0] en,
   input  logic [NUM_TPCS-1:0] sync_request,
   output logic                global_sync_out,
   output logic [NUM_TPCS-1:0] sync_grant
);

   logic cond;
   logic cond_q;
   logic release_now;

   // Barrier condition and its rising edge; a partial request set never releases
   always_comb begin
      cond        = (en != '0) && ((sync_request & en) == en);
      release_now = cond & ~cond_q;
   end

   // Edge-detect register and registered one-cycle release outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cond_q          <= 1'b0;
         global_sync_out <= 1'b0;
         sync_grant      <= '0;
      end else begin
         cond_q          <= cond;
         global_sync_out <= release_now;
         sync_grant      <= release_now ? en : '0;
      end
   end

endmodule

// File: rtl/global_cmd_processor.sv
// Global command processor: AXI4-Lite register file that launches the TPCs,
// reports their status, runs the cross-TPC barrier and drives the host IRQ.
// Optional feature macro: GCP_PERF_COUNTER_EN (adds PERF_CYCLES at 0x010).
module global_cmd_processor
   import gcp_pkg::*;
#(
   parameter int unsigned NUM_TPCS = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [11:0]         s_axi_awaddr,
   input  logic                s_axi_awvalid,
   output logic                s_axi_awready,
   input  logic [31:0]         s_axi_wdata,
   input  logic [3:0]          s_axi_wstrb,
   input  logic                s_axi_wvalid,
   output logic                s_axi_wready,
   output logic [1:0]          s_axi_bresp,
   output logic                s_axi_bvalid,
   input  logic                s_axi_bready,
   input  logic [11:0]         s_axi_araddr,
   input  logic                s_axi_arvalid,
   output logic                s_axi_arready,
   output logic [31:0]         s_axi_rdata,
   output logic [1:0]          s_axi_rresp,
   output logic                s_axi_rvalid,
   input  logic                s_axi_rready,
   output logic [NUM_TPCS-1:0] tpc_start,
   output logic [PC_W-1:0]     tpc_start_pc [0:NUM_TPCS-1],
   input  logic [NUM_TPCS-1:0] tpc_busy,
   input  logic [NUM_TPCS-1:0] tpc_done,
   input  logic [NUM_TPCS-1:0] tpc_error,
   output logic                global_sync_out,
   input  logic [NUM_TPCS-1:0] sync_request,
   output logic [NUM_TPCS-1:0] sync_grant,
   output logic                irq
);

   logic                wr_hs;
   logic                rd_hs;
   logic [7:0]          mask_q;
   logic [NUM_TPCS-1:0] en;
   logic [PC_W-1:0]     start_pc_q [0:NUM_TPCS-1];
   logic [1:0]          irq_en_q;
   logic [1:0]          irq_status_q;
   logic [1:0]          irq_set;
   logic [1:0]          irq_w1c;
   logic                all_done;
   logic                all_done_q;
   logic                err_any;
   logic                err_any_q;
   logic                wr_ctrl;
   logic                wr_irq_en;
   logic                wr_irq_stat;
   logic                start_issue;
   logic [NUM_TPCS-1:0] wr_pc_sel;
   logic [31:0]         rd_data;
   logic                unused_wr_bits;

   // Write strobes and the upper data bits never reach any register
   assign unused_wr_bits = ^{s_axi_wstrb, s_axi_wdata[31:PC_W]};

   assign wr_hs         = s_axi_awvalid & s_axi_wvalid & ~s_axi_bvalid;
   assign s_axi_awready = wr_hs;
   assign s_axi_wready  = wr_hs;
   assign s_axi_bresp   = RESP_OKAY;
   assign rd_hs         = s_axi_arvalid & ~s_axi_rvalid;
   assign s_axi_arready = rd_hs;
   assign s_axi_rresp   = RESP_OKAY;

   assign en           = mask_q[NUM_TPCS-1:0];
   assign tpc_start_pc = start_pc_q;

   // Write decode and status/interrupt event detection
   always_comb begin
      wr_ctrl     = wr_hs && (s_axi_awaddr == ADDR_CTRL);
      wr_irq_en   = wr_hs && (s_axi_awaddr == ADDR_IRQ_EN);
      wr_irq_stat = wr_hs && (s_axi_awaddr == ADDR_IRQ_STATUS);
      start_issue = wr_ctrl && s_axi_wdata[CTRL_START_BIT];
      wr_pc_sel   = '0;
      for (int unsigned i = 0; i < NUM_TPCS; i++) begin
         wr_pc_sel[i] = wr_hs && tpc_window(s_axi_awaddr)
                        && ({29'd0, tpc_index(s_axi_awaddr)} == i)
                        && (s_axi_awaddr[3:0] == TPC_OFS_PC);
      end
      all_done = (en != '0) && ((tpc_done & en) == en);
      err_any  = |(tpc_error & en);
      irq_set  = {err_any & ~err_any_q, all_done & ~all_done_q};
      irq_w1c  = wr_irq_stat ? s_axi_wdata[1:0] : 2'b00;
   end

   // Write response channel
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s_axi_bvalid <= 1'b0;
      end else if (wr_hs) begin
         s_axi_bvalid <= 1'b1;
      end else if (s_axi_bready) begin
         s_axi_bvalid <= 1'b0;
      end
   end

   // Control registers and the one-cycle start pulse (uses the mask being written)
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mask_q    <= '1;
         irq_en_q  <= '0;
         tpc_start <= '0;
      end else begin
         if (wr_ctrl) begin
            mask_q <= s_axi_wdata[CTRL_MASK_LSB +: 8];
         end
         if (wr_irq_en) begin
            irq_en_q <= s_axi_wdata[1:0];
         end
         tpc_start <= start_issue ? s_axi_wdata[CTRL_MASK_LSB +: NUM_TPCS] : '0;
      end
   end

   // Per-TPC start PC registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < NUM_TPCS; i++) begin
            start_pc_q[i] <= '0;
         end
      end else begin
         for (int unsigned i = 0; i < NUM_TPCS; i++) begin
            if (wr_pc_sel[i]) begin
               start_pc_q[i] <= s_axi_wdata[PC_W-1:0];
            end
         end
      end
   end

   // Interrupt status (set beats same-cycle W1C) and registered irq output
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         all_done_q   <= 1'b0;
         err_any_q    <= 1'b0;
         irq_status_q <= '0;
         irq          <= 1'b0;
      end else begin
         all_done_q   <= all_done;
         err_any_q    <= err_any;
         irq_status_q <= irq_set | (irq_status_q & ~irq_w1c);
         irq          <= |(irq_status_q & irq_en_q);
      end
   end

`ifdef GCP_PERF_COUNTER_EN
   logic [31:0] perf_q;
   logic        perf_clr;

   assign perf_clr = (wr_hs && (s_axi_awaddr == ADDR_PERF)) || start_issue;

   // Busy-cycle counter; clearing takes priority over counting
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_q <= '0;
      end else if (perf_clr) begin
         perf_q <= '0;
      end else if (|(tpc_busy & en)) begin
         perf_q <= perf_q + 32'd1;
      end
   end
`endif

   // Read data mux; unmapped addresses return zero
   always_comb begin
      rd_data = '0;
      if (s_axi_araddr == ADDR_CTRL) begin
         rd_data[CTRL_MASK_LSB +: 8] = mask_q;
      end else if (s_axi_araddr == ADDR_STATUS) begin
         rd_data[STAT_BUSY_LSB +: 8]    = 8'(tpc_busy);
         rd_data[STAT_DONE_LSB +: 8]    = 8'(tpc_done);
         rd_data[STAT_ERR_LSB +: 8]     = 8'(tpc_error);
         rd_data[STAT_ALL_DONE_BIT]     = all_done;
      end else if (s_axi_araddr == ADDR_IRQ_EN) begin
         rd_data[1:0] = irq_en_q;
      end else if (s_axi_araddr == ADDR_IRQ_STATUS) begin
         rd_data[IRQ_ERR_BIT:IRQ_DONE_BIT] = irq_status_q;
      end
`ifdef GCP_PERF_COUNTER_EN
      else if (s_axi_araddr == ADDR_PERF) begin
         rd_data = perf_q;
      end
`endif
      else if (tpc_window(s_axi_araddr)) begin
         for (int unsigned i = 0; i < NUM_TPCS; i++) begin
            if ({29'd0, tpc_index(s_axi_araddr)} == i) begin
               if (s_axi_araddr[3:0] == TPC_OFS_PC) begin
                  rd_data[PC_W-1:0] = start_pc_q[i];
               end else if (s_axi_araddr[3:0] == TPC_OFS_STAT) begin
                  rd_data[2:0] = {tpc_error[i], tpc_done[i], tpc_busy[i]};
               end
            end
         end
      end
   end

   // Read data channel
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s_axi_rvalid <= 1'b0;
         s_axi_rdata  <= '0;
      end else if (rd_hs) begin
         s_axi_rvalid <= 1'b1;
         s_axi_rdata  <= rd_data;
      end else if (s_axi_rready) begin
         s_axi_rvalid <= 1'b0;
      end
   end

   gcp_barrier #(
      .NUM_TPCS(NUM_TPCS)
   ) u_barrier (
      .clk             (clk),
      .rst_n           (rst_n),
      .en              (en),
      .sync_request    (sync_request),
      .global_sync_out (global_sync_out),
      .sync_grant      (sync_grant)
   );

endmodule

// File: tb/tb_global_cmd_processor.sv
// Directed bench for global_cmd_processor (default build, NUM_TPCS = 4).
module tb_global_cmd_processor;

   localparam int unsigned N = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [11:0]   s_axi_awaddr = '0;
   logic          s_axi_awvalid = 1'b0;
   logic          s_axi_awready;
   logic [31:0]   s_axi_wdata = '0;
   logic [3:0]    s_axi_wstrb = 4'hF;
   logic          s_axi_wvalid = 1'b0;
   logic          s_axi_wready;
   logic [1:0]    s_axi_bresp;
   logic          s_axi_bvalid;
   logic          s_axi_bready = 1'b0;
   logic [11:0]   s_axi_araddr = '0;
   logic          s_axi_arvalid = 1'b0;
   logic          s_axi_arready;
   logic [31:0]   s_axi_rdata;
   logic [1:0]    s_axi_rresp;
   logic          s_axi_rvalid;
   logic          s_axi_rready = 1'b0;
   logic [N-1:0]  tpc_start;
   logic [19:0]   tpc_start_pc [0:N-1];
   logic [N-1:0]  tpc_busy = '0;
   logic [N-1:0]  tpc_done = '0;
   logic [N-1:0]  tpc_error = '0;
   logic          global_sync_out;
   logic [N-1:0]  sync_request = '0;
   logic [N-1:0]  sync_grant;
   logic          irq;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   global_cmd_processor #(
      .NUM_TPCS(N)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .s_axi_awaddr    (s_axi_awaddr),
      .s_axi_awvalid   (s_axi_awvalid),
      .s_axi_awready   (s_axi_awready),
      .s_axi_wdata     (s_axi_wdata),
      .s_axi_wstrb     (s_axi_wstrb),
      .s_axi_wvalid    (s_axi_wvalid),
      .s_axi_wready    (s_axi_wready),
      .s_axi_bresp     (s_axi_bresp),
      .s_axi_bvalid    (s_axi_bvalid),
      .s_axi_bready    (s_axi_bready),
      .s_axi_araddr    (s_axi_araddr),
      .s_axi_arvalid   (s_axi_arvalid),
      .s_axi_arready   (s_axi_arready),
      .s_axi_rdata     (s_axi_rdata),
      .s_axi_rresp     (s_axi_rresp),
      .s_axi_rvalid    (s_axi_rvalid),
      .s_axi_rready    (s_axi_rready),
      .tpc_start       (tpc_start),
      .tpc_start_pc    (tpc_start_pc),
      .tpc_busy        (tpc_busy),
      .tpc_done        (tpc_done),
      .tpc_error       (tpc_error),
      .global_sync_out (global_sync_out),
      .sync_request    (sync_request),
      .sync_grant      (sync_grant),
      .irq             (irq)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic axi_write(input logic [11:0] a, input logic [31:0] d,
                            output logic [N-1:0] st_hs, output logic [N-1:0] st_nx);
      int n;
      @(negedge clk);
      s_axi_awaddr  = a;
      s_axi_wdata   = d;
      s_axi_awvalid = 1'b1;
      s_axi_wvalid  = 1'b1;
      #1;
      n = 0;
      while (!s_axi_awready && n < 20) begin
         @(negedge clk);
         #1;
         n++;
      end
      chk("aw_ready", 32'(s_axi_awready), 32'd1);
      @(posedge clk);
      #1;
      s_axi_awvalid = 1'b0;
      s_axi_wvalid  = 1'b0;
      st_hs = tpc_start;
      chk("bvalid_bresp", {29'd0, s_axi_bvalid, s_axi_bresp}, 32'd4);
      s_axi_bready = 1'b1;
      @(posedge clk);
      #1;
      st_nx = tpc_start;
      s_axi_bready = 1'b0;
   endtask

   task automatic wr(input logic [11:0] a, input logic [31:0] d);
      logic [N-1:0] s0, s1;
      axi_write(a, d, s0, s1);
   endtask

   task automatic rd_chk(input string tag, input logic [11:0] a, input logic [31:0] exp);
      int n;
      @(negedge clk);
      s_axi_araddr  = a;
      s_axi_arvalid = 1'b1;
      #1;
      n = 0;
      while (!s_axi_arready && n < 20) begin
         @(negedge clk);
         #1;
         n++;
      end
      chk("ar_ready", 32'(s_axi_arready), 32'd1);
      @(posedge clk);
      #1;
      s_axi_arvalid = 1'b0;
      chk("rvalid_rresp", {29'd0, s_axi_rvalid, s_axi_rresp}, 32'd4);
      chk(tag, s_axi_rdata, exp);
      s_axi_rready = 1'b1;
      @(posedge clk);
      #1;
      s_axi_rready = 1'b0;
   endtask

   initial begin
      logic [N-1:0] hs, nx, grant_seen;
      int pulses, first, n;

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_start", 32'(tpc_start), 32'd0);
      chk("rst_irq", 32'(irq), 32'd0);
      chk("rst_sync", {27'd0, global_sync_out, sync_grant}, 32'd0);
      chk("rst_axi_valid", {30'd0, s_axi_bvalid, s_axi_rvalid}, 32'd0);
      chk("rst_rdata", s_axi_rdata, 32'd0);
      rst_n = 1'b1;
      chk("rst_pc0", 32'(tpc_start_pc[0]), 32'd0);
      rd_chk("ctrl_reset", 12'h000, 32'h0000_FF00);
      rd_chk("irq_en_reset", 12'h008, 32'd0);
      rd_chk("irq_stat_reset", 12'h00C, 32'd0);

      // Start PC registers
      wr(12'h100, 32'h0000_1000);
      wr(12'h110, 32'h0000_2000);
      rd_chk("pc0_rd", 12'h100, 32'h0000_1000);
      rd_chk("pc1_rd", 12'h110, 32'h0000_2000);
      chk("pc0_port", 32'(tpc_start_pc[0]), 32'h0_1000);
      chk("pc1_port", 32'(tpc_start_pc[1]), 32'h0_2000);
      wr(12'h120, 32'hFFF1_2345);
      rd_chk("pc2_upper_dropped", 12'h120, 32'h0001_2345);
      chk("pc2_port", 32'(tpc_start_pc[2]), 32'h1_2345);
      wr(12'h140, 32'h000A_BCDE);
      rd_chk("pc4_unmapped", 12'h140, 32'd0);
      chk("pc3_untouched", 32'(tpc_start_pc[3]), 32'd0);
      chk("pc0_untouched", 32'(tpc_start_pc[0]), 32'h0_1000);
      rd_chk("perf_unmapped", 12'h010, 32'd0);
      rd_chk("unmapped_0fc", 12'h0FC, 32'd0);

      // START pulses
      axi_write(12'h000, 32'h0000_FF01, hs, nx);
      chk("start_all", 32'(hs), 32'hF);
      chk("start_all_one_cycle", 32'(nx), 32'h0);
      rd_chk("ctrl_start_reads0", 12'h000, 32'h0000_FF00);
      axi_write(12'h000, 32'h0000_0300, hs, nx);
      chk("no_start_bit0_clear", 32'(hs), 32'h0);
      axi_write(12'h000, 32'h0000_0301, hs, nx);
      chk("start_masked", 32'(hs), 32'h3);
      chk("start_masked_one_cycle", 32'(nx), 32'h0);

      // STATUS and per-TPC status
      tpc_busy = 4'b1010;
      tpc_done = 4'b0101;
      rd_chk("status_mix", 12'h004, 32'h0000_050A);
      rd_chk("tpc0_stat", 12'h104, 32'd2);
      rd_chk("tpc1_stat", 12'h114, 32'd1);

      // Barrier: partial request set never grants
      wr(12'h000, 32'h0000_0F00);
      @(negedge clk);
      sync_request = 4'b0011;
      pulses = 0; grant_seen = '0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (global_sync_out) pulses++;
         grant_seen |= sync_grant;
      end
      chk("bar_partial_pulse", 32'(pulses), 32'd0);
      chk("bar_partial_grant", 32'(grant_seen), 32'd0);
      sync_request = 4'b1111;
      pulses = 0; grant_seen = '0; first = 99;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (global_sync_out) begin
            pulses++;
            if (first == 99) first = i;
         end
         grant_seen |= sync_grant;
      end
      chk("bar_full_pulse", 32'(pulses), 32'd1);
      chk("bar_full_grant", 32'(grant_seen), 32'hF);
      chk("bar_full_latency", 32'(first <= 1), 32'd1);
      sync_request = '0;
      repeat (2) @(negedge clk);
      sync_request = 4'b1111;
      pulses = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (global_sync_out) pulses++;
      end
      chk("bar_rearm_pulse", 32'(pulses), 32'd1);

      // Barrier with mask only on non-existent TPCs: no release
      sync_request = '0;
      wr(12'h000, 32'h0000_F000);
      @(negedge clk);
      sync_request = 4'b1111;
      pulses = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (global_sync_out) pulses++;
      end
      chk("bar_empty_mask", 32'(pulses), 32'd0);

      // Mask 0x13: upper bit ignored, en = 0011
      sync_request = '0;
      wr(12'h000, 32'h0000_1300);
      @(negedge clk);
      sync_request = 4'b0011;
      pulses = 0; grant_seen = '0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (global_sync_out) pulses++;
         grant_seen |= sync_grant;
      end
      chk("bar_mask13_pulse", 32'(pulses), 32'd1);
      chk("bar_mask13_grant", 32'(grant_seen), 32'h3);
      rd_chk("ctrl_mask13", 12'h000, 32'h0000_1300);
      sync_request = '0;

      // Done interrupt
      axi_write(12'h000, 32'h0000_FF01, hs, nx);
      chk("start_before_irq", 32'(hs), 32'hF);
      wr(12'h008, 32'h0000_0001);
      rd_chk("irq_stat_idle", 12'h00C, 32'd0);
      chk("irq_idle", 32'(irq), 32'd0);
      @(negedge clk);
      tpc_done = 4'b1111;
      n = 0;
      while (!irq && n < 5) begin
         @(negedge clk);
         n++;
      end
      chk("irq_done_rise", 32'(irq), 32'd1);
      rd_chk("irq_stat_done", 12'h00C, 32'd1);
      wr(12'h00C, 32'h0000_0001);
      chk("irq_cleared", 32'(irq), 32'd0);
      pulses = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (irq) pulses++;
      end
      chk("irq_stays_low", 32'(pulses), 32'd0);
      rd_chk("irq_stat_w1c", 12'h00C, 32'd0);

      // Error interrupt and all_done status
      wr(12'h008, 32'h0000_0003);
      @(negedge clk);
      tpc_error = 4'b0100;
      n = 0;
      while (!irq && n < 5) begin
         @(negedge clk);
         n++;
      end
      chk("irq_err_rise", 32'(irq), 32'd1);
      rd_chk("irq_stat_err", 12'h00C, 32'd2);
      rd_chk("status_all_done", 12'h004, 32'h8004_0F0A);
      rd_chk("tpc2_stat", 12'h124, 32'd6);
      rd_chk("irq_en_rd", 12'h008, 32'd3);
      wr(12'h00C, 32'h0000_0002);
      chk("irq_err_cleared", 32'(irq), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Absolute time bound
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/global_cmd_processor.md
Name: global_cmd_processor

Overview:
- Top-level control block of the tensor accelerator. Software programs it through an AXI4-Lite slave.
- It launches the TPCs (tensor processing clusters) with per-TPC start PCs and reports their busy/done/error status.
- It implements a hardware barrier across the enabled TPCs and raises a single interrupt to the host.

Parameters:
- NUM_TPCS, 4, number of TPCs controlled; legal range 1..8.

Ports:
- clk  in  1  system clock; everything is synchronous to its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- s_axi_awaddr  in  12  write address.
- s_axi_awvalid / s_axi_awready  in / out  1  write address handshake.
- s_axi_wdata  in  32  write data.
- s_axi_wstrb  in  4  write strobes; ignored, full-word writes only.
- s_axi_wvalid / s_axi_wready  in / out  1  write data handshake.
- s_axi_bresp  out  2  write response, always 2'b00 (OKAY).
- s_axi_bvalid / s_axi_bready  out / in  1  write response handshake.
- s_axi_araddr  in  12  read address.
- s_axi_arvalid / s_axi_arready  in / out  1  read address handshake.
- s_axi_rdata  out  32  read data.
- s_axi_rresp  out  2  read response, always 2'b00 (OKAY).
- s_axi_rvalid / s_axi_rready  out / in  1  read data handshake.
- tpc_start  out  NUM_TPCS  one-cycle start pulse per TPC.
- tpc_start_pc  out  20 x [0:NUM_TPCS-1]  unpacked array; start PC of each TPC.
- tpc_busy, tpc_done, tpc_error  in  NUM_TPCS each  TPC status levels.
- global_sync_out  out  1  one-cycle barrier-release pulse.
- sync_request  in  NUM_TPCS  barrier request from each TPC.
- sync_grant  out  NUM_TPCS  barrier grant per TPC.
- irq  out  1  level interrupt to the host.

Behaviour:
- Reset values: every output is 0; enable mask = 0xFF; all start PCs = 0; IRQ_EN = 0; IRQ_STATUS = 0.
- AXI write:
  - awready = wready = awvalid & wvalid & !bvalid (combinational). AW and W always handshake in the same cycle.
  - The register update and bvalid<=1 both happen on that clock edge.
  - bvalid holds until bready is high, then clears.
- AXI read:
  - arready = arvalid & !rvalid.
  - On the handshake edge, rvalid<=1 and rdata is registered.
  - rvalid holds until rready is high.
- Unmapped addresses: reads return 0, writes are ignored, response is OKAY.
- Register map:
  - 0x000 CTRL (RW):
    - [15:8] enable mask; bit i enables TPC i.
    - [0] START, write-1 only; always reads 0.
    - A write with bit0=1 updates the mask first. One cycle after the handshake edge, tpc_start = new_mask[NUM_TPCS-1:0] for exactly one cycle.
  - 0x004 STATUS (RO):
    - [7:0] busy, [15:8] done, [23:16] error.
    - Each field is zero-extended from NUM_TPCS bits.
    - [31] all_done = (done & en) == en, with en != 0.
  - 0x008 IRQ_EN (RW): [0] done interrupt enable, [1] error interrupt enable.
  - 0x00C IRQ_STATUS (W1C):
    - [0] sets on a rising edge of all_done.
    - [1] sets on a rising edge of |(tpc_error & en).
    - If a set event and a W1C clear hit the same bit in the same cycle, set wins.
  - 0x100 + 16*i, for i < NUM_TPCS:
    - Offset +0: start PC (RW). Bits [19:0] are stored; upper bits ignored on write and read back as 0.
    - Offset +4: per-TPC status (RO), {error, done, busy} in [2:0].
- irq = |(IRQ_STATUS[1:0] & IRQ_EN[1:0]), registered. Clearing a status bit while its condition stays high does not re-set it until the next rising edge.
- Barrier:
  - Condition: en != 0 and (sync_request & en) == en, where en = mask[NUM_TPCS-1:0].
  - On a rising edge of the condition (registered edge detect), global_sync_out = 1 and sync_grant = en for one cycle.
  - No grant is issued while the request set is only partial.
  - The condition must fall before the barrier re-arms.
  - Mask bits for TPCs that do not exist are ignored.
- tpc_start_pc[i] is driven continuously from its register.

Optional Feature:
- Macro: GCP_PERF_COUNTER_EN.
- When defined:
  - Register 0x010 PERF_CYCLES (RO, 32 bits) counts cycles in which |(tpc_busy & en) is true. It wraps at 2^32.
  - Any write to 0x010 clears it.
  - It also clears when a START is issued.
- When not defined: 0x010 is unmapped (reads 0) and no counter logic exists.

Decomposition:
- Package gcp_pkg holds:
  - address localparams ADDR_CTRL=0x000, ADDR_STATUS=0x004, ADDR_IRQ_EN=0x008, ADDR_IRQ_STATUS=0x00C, ADDR_PERF=0x010, ADDR_TPC_BASE=0x100, TPC_STRIDE=16;
  - field positions;
  - OKAY response code.
- One sub-module is natural: gcp_barrier, containing the barrier condition, edge detect, and sync_grant / global_sync_out generation.

Test Plan:
- After reset, read CTRL -> rdata[15:8]=0xFF, rdata[0]=0.
- Write 0x100=0x1000 and 0x110=0x2000, then read both back -> 0x00001000 and 0x00002000; tpc_start_pc[0]=0x01000 and tpc_start_pc[1]=0x02000.
- Write CTRL=0x0000FF01 -> tpc_start=4'b1111 for exactly one cycle. Then write CTRL=0x300 followed by 0x301 -> tpc_start=4'b0011.
- Drive busy=4'b1010 and done=4'b0101, read STATUS -> [3:0]=4'b1010, [11:8]=4'b0101, [31]=0.
- Write CTRL=0xF00, drive sync_request=4'b0011 -> sync_grant=0. Then drive 4'b1111 -> within 2 cycles global_sync_out pulses once and sync_grant=4'b1111 for one cycle.
- Write CTRL=0xFF01 and IRQ_EN=1, then drive done 4'b0101->4'b1111 -> irq=1 within 5 cycles. Write IRQ_STATUS=1 -> irq=0 and stays 0 while done is held high.
